// File: rtl/xc_malu_multiply.sv
// Sequential radix-2 shift-add multiplier: 32x32 -> 64-bit product, one bit per cycle,
// using the shared MALU packed adder. Covers mul/mulh/mulhsu/mulhu sign modes.
module xc_malu_multiply (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        valid,
    input  logic        op_signed_lhs,
    input  logic        op_signed_rhs,
    input  logic        flush,
    output logic [31:0] padd_lhs,
    output logic [31:0] padd_rhs,
    output logic        padd_sub,
    input  logic [31:0] padd_carry,
    input  logic [31:0] padd_result,
    output logic [63:0] result,
    output logic        finished
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } fsm_t;

    fsm_t        fsm_reg,   fsm_next;
    logic [4:0]  cnt_reg,   cnt_next;
    logic [63:0] acc_reg,   acc_next;
    logic [31:0] mcand_reg, mcand_next;
    logic        neg_reg,   neg_next;

    logic        sign_lhs;
    logic        sign_rhs;
    logic [31:0] mag_lhs;
    logic [31:0] mag_rhs;
    logic        in_run;
    logic        add_en;

    // Only the top carry feeds the accumulator; lower carries belong to the divider.
    logic        unused_carry;
    assign unused_carry = ^padd_carry[30:0];

    // Operands are reduced to magnitudes; 0x80000000 negates to itself, which read
    // unsigned is exactly 2^31, so no overflow special case is needed.
    assign sign_lhs = op_signed_lhs & rs1[31];
    assign sign_rhs = op_signed_rhs & rs2[31];
    assign mag_lhs  = sign_lhs ? (~rs1 + 32'd1) : rs1;
    assign mag_rhs  = sign_rhs ? (~rs2 + 32'd1) : rs2;

    assign in_run   = (fsm_reg == RUN);
    assign add_en   = in_run & acc_reg[0];

    assign padd_lhs = in_run ? acc_reg[63:32] : 32'd0;
    assign padd_sub = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_rhs_mask
            assign padd_rhs[gi] = add_en & mcand_reg[gi];
        end
    endgenerate

    assign finished = (fsm_reg == DONE);
    assign result   = acc_reg;

    always_comb begin
        fsm_next   = fsm_reg;
        cnt_next   = cnt_reg;
        acc_next   = acc_reg;
        mcand_next = mcand_reg;
        neg_next   = neg_reg;

        if (flush) begin
            fsm_next = IDLE;
            cnt_next = 5'd0;
        end else begin
            case (fsm_reg)
                IDLE: begin
                    if (valid) begin
                        fsm_next   = RUN;
                        cnt_next   = 5'd0;
                        acc_next   = {32'd0, mag_lhs};
                        mcand_next = mag_rhs;
                        neg_next   = sign_lhs ^ sign_rhs;
                    end
                end
                RUN: begin
                    // Add into the high half, then shift the 33-bit sum down one place.
                    acc_next = {padd_carry[31], padd_result, acc_reg[31:1]};
                    cnt_next = cnt_reg + 5'd1;
                    if (cnt_reg == 5'd31) begin
                        fsm_next = FIX;
                    end
                end
                FIX: begin
                    // Runs even for positive results so latency is data independent.
                    acc_next = neg_reg ? (~acc_reg + 64'd1) : acc_reg;
                    fsm_next = DONE;
                end
                DONE: begin
                    if (!valid) begin
                        fsm_next = IDLE;
                    end
                end
                default: begin
                    fsm_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fsm_reg   <= IDLE;
            cnt_reg   <= 5'd0;
            acc_reg   <= 64'd0;
            mcand_reg <= 32'd0;
            neg_reg   <= 1'b0;
        end else begin
            fsm_reg   <= fsm_next;
            cnt_reg   <= cnt_next;
            acc_reg   <= acc_next;
            mcand_reg <= mcand_next;
            neg_reg   <= neg_next;
        end
    end

endmodule
